// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner:
// FSM state encoding, row strobe helpers and the row/column to hex key map.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Indexed by {row, col}; row 3 carries the non-sequential E,0,F,D legends
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   function automatic logic [3:0] row_strobe(input logic [1:0] i_row);
      return ~(4'b0001 << i_row);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, with a selectable
// reset value so idle (pulled-up) lines come out of reset inactive.
module sync2 #(
   parameter int                  WIDTH     = 4,
   parameter logic [WIDTH-1:0]    RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: rotating active-low row strobe, debounced press and
// release, and a 4-digit shift register feeding the seven-segment display.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV_BITS  = 16,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  cols,
   output logic [3:0]  rows,
   output logic [15:0] data_out,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held
);

   logic [SCAN_DIV_BITS-1:0] r_presc;
   logic                     w_tick;
   logic [3:0]               w_cols_s;

   state_t      r_state;
   logic [1:0]  r_row;
   logic [3:0]  r_rows;
   logic [1:0]  r_cand_r;
   logic [1:0]  r_cand_c;
   logic [3:0]  r_cnt;
   logic [15:0] r_data;
   logic [3:0]  r_code;
   logic        r_valid;
   logic        r_held;

   logic        w_col_hit;
   logic [1:0]  w_col_idx;
   logic        w_same_key;
   logic        w_all_high;
   logic [4:0]  w_cnt_inc;
   logic        w_cnt_done;
   logic [1:0]  w_row_next;
   logic [1:0]  w_cand_next;
   logic [3:0]  w_cand_code;

   sync2 #(
      .WIDTH     (4),
      .RESET_VAL (4'hF)
   ) u_cols_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (cols),
      .o_q   (w_cols_s)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   assign w_tick = &r_presc;

   // Exactly one low column is a key; zero or several lows are ignored
   always_comb begin
      w_col_hit = 1'b0;
      w_col_idx = 2'd0;
      unique case (w_cols_s)
         4'b1110: begin w_col_hit = 1'b1; w_col_idx = 2'd0; end
         4'b1101: begin w_col_hit = 1'b1; w_col_idx = 2'd1; end
         4'b1011: begin w_col_hit = 1'b1; w_col_idx = 2'd2; end
         4'b0111: begin w_col_hit = 1'b1; w_col_idx = 2'd3; end
         default: begin w_col_hit = 1'b0; w_col_idx = 2'd0; end
      endcase
   end

   assign w_same_key  = w_col_hit && (w_col_idx == r_cand_c);
   assign w_all_high  = (w_cols_s == 4'hF);
   assign w_cnt_inc   = {1'b0, r_cnt} + 5'd1;
   assign w_cnt_done  = (w_cnt_inc >= 5'(DEBOUNCE_TICKS));
   assign w_row_next  = r_row + 2'd1;
   assign w_cand_next = r_cand_r + 2'd1;
   assign w_cand_code = KEY_MAP[{r_cand_r, r_cand_c}];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= SCAN;
         r_row    <= 2'd0;
         r_rows   <= ROW_RESET;
         r_cand_r <= 2'd0;
         r_cand_c <= 2'd0;
         r_cnt    <= 4'd0;
         r_data   <= 16'h0000;
         r_code   <= 4'h0;
         r_valid  <= 1'b0;
         r_held   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_tick) begin
            unique case (r_state)
               SCAN: begin
                  if (w_col_hit) begin
                     r_cand_r <= r_row;
                     r_cand_c <= w_col_idx;
                     r_cnt    <= 4'd1;
                     r_state  <= PRESS_DB;
                  end else begin
                     r_row  <= w_row_next;
                     r_rows <= row_strobe(w_row_next);
                  end
               end
               PRESS_DB: begin
                  if (w_same_key) begin
                     if (w_cnt_done) begin
                        r_code  <= w_cand_code;
                        r_data  <= {r_data[11:0], w_cand_code};
                        r_valid <= 1'b1;
                        r_held  <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= HELD;
                     end else begin
                        r_cnt <= w_cnt_inc[3:0];
                     end
                  end else begin
                     r_cnt   <= 4'd0;
                     r_row   <= w_row_next;
                     r_rows  <= row_strobe(w_row_next);
                     r_state <= SCAN;
                  end
               end
               HELD: begin
                  // Any low column, including a second key, restarts the release count
                  if (w_all_high) begin
                     if (w_cnt_done) begin
                        r_held  <= 1'b0;
                        r_cnt   <= 4'd0;
                        r_row   <= w_cand_next;
                        r_rows  <= row_strobe(w_cand_next);
                        r_state <= SCAN;
                     end else begin
                        r_cnt <= w_cnt_inc[3:0];
                     end
                  end else begin
                     r_cnt <= 4'd0;
                  end
               end
               default: r_state <= SCAN;
            endcase
         end
      end
   end

   assign rows      = r_rows;
   assign data_out  = r_data;
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_held  = r_held;

`ifndef SYNTHESIS
   a_one_row_low : assert property (@(posedge clk) disable iff (!rst_n) $onehot(~rows));
   a_valid_pulse : assert property (@(posedge clk) disable iff (!rst_n) key_valid |=> !key_valid);
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural keypad drives cols from rows, and a
// scoreboard of expected {code, data, held} records is matched to key_valid pulses.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  cols;
   logic [3:0]  rows;
   logic [15:0] data_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic       k0_en = 1'b0;
   logic [1:0] k0_r = 2'd0;
   logic [1:0] k0_c = 2'd0;
   logic       k1_en = 1'b0;
   logic [1:0] k1_r = 2'd0;
   logic [1:0] k1_c = 2'd0;

   typedef struct packed {
      logic [3:0]  code;
      logic [15:0] data;
      logic        held;
   } obs_t;

   typedef struct {
      logic [1:0]  r;
      logic [1:0]  c;
      logic [3:0]  code;
      logic [15:0] data;
   } vec_t;

   obs_t obs_q[$];
   obs_t exp_q[$];
   int   rd_idx   = 0;
   int   wide_cnt = 0;
   logic prev_v   = 1'b0;
   int   n_vec    = 0;
   int   n_err    = 0;
   vec_t vecs[5];

   keypad_scanner #(
      .SCAN_DIV_BITS  (2),
      .DEBOUNCE_TICKS (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cols      (cols),
      .rows      (rows),
      .data_out  (data_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // A pressed key pulls its column low only while its row is strobed
   always_comb begin
      cols = 4'hF;
      if (k0_en && (rows[k0_r] == 1'b0)) cols[k0_c] = 1'b0;
      if (k1_en && (rows[k1_r] == 1'b0)) cols[k1_c] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid) begin
         obs_q.push_back('{code: key_code, data: data_out, held: key_held});
         if (prev_v) wide_cnt++;
      end
      prev_v = key_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic press(input logic [1:0] r, input logic [1:0] c);
      k0_r  = r;
      k0_c  = c;
      k0_en = 1'b1;
   endtask

   task automatic release_all();
      k0_en = 1'b0;
      k1_en = 1'b0;
   endtask

   task automatic expect_pulse(input string name, input int budget);
      bit   seen = 1'b0;
      obs_t e;
      obs_t o;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (obs_q.size() > rd_idx) seen = 1'b1;
      end
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no key_valid within %0d clks, expected code %h", name, budget, e.code);
      end else begin
         o = obs_q[rd_idx];
         rd_idx++;
         check({name, "_code"}, 16'(o.code), 16'(e.code));
         check({name, "_data"}, o.data, e.data);
         check({name, "_held"}, 16'(o.held), 16'(e.held));
      end
   endtask

   task automatic wait_held_low(input int budget, output int clks);
      for (clks = 1; clks <= budget; clks++) begin
         @(negedge clk);
         if (!key_held) break;
      end
   endtask

   task automatic check_no_new(input string name);
      check(name, 16'(obs_q.size()), 16'(rd_idx));
   endtask

   initial begin
      int         clks;
      logic [3:0] er;

      vecs[0] = '{r: 2'd0, c: 2'd0, code: 4'h1, data: 16'h0061};
      vecs[1] = '{r: 2'd0, c: 2'd1, code: 4'h2, data: 16'h0612};
      vecs[2] = '{r: 2'd0, c: 2'd2, code: 4'h3, data: 16'h6123};
      vecs[3] = '{r: 2'd0, c: 2'd3, code: 4'hA, data: 16'h123A};
      vecs[4] = '{r: 2'd1, c: 2'd1, code: 4'h5, data: 16'h23A5};

      // Reset with a key held down, then watch the row rotation
      rst_n = 1'b0;
      press(2'd1, 2'd2);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("rst_rows", 16'(rows), 16'h000E);
      check("rst_data", data_out, 16'h0000);
      check("rst_code", 16'(key_code), 16'h0000);
      check("rst_held", 16'(key_held), 16'h0000);
      check_no_new("rst_no_valid");
      release_all();
      rst_n = 1'b1;
      check("rot_rows0", 16'(rows), 16'h000E);
      for (int i = 1; i <= 4; i++) begin
         repeat (4) @(posedge clk);
         @(negedge clk);
         er = ~(4'b0001 << (i % 4));
         check($sformatf("rot_rows%0d", i), 16'(rows), 16'(er));
      end

      // Single press of key 6 and its debounced release
      press(2'd1, 2'd2);
      exp_q.push_back('{code: 4'h6, data: 16'h0006, held: 1'b1});
      expect_pulse("press6", 120);
      repeat (24) @(negedge clk);
      check_no_new("press6_no_repeat");
      check("press6_held", 16'(key_held), 16'h0001);
      release_all();
      wait_held_low(100, clks);
      check("press6_release_clks", 16'((clks >= 11) && (clks <= 14)), 16'h0001);
      if (!((clks >= 11) && (clks <= 14)))
         $display("  release took %0d clks", clks);
      repeat (8) @(negedge clk);
      check_no_new("press6_single");

      // Digit entry through wrap-around
      foreach (vecs[i]) begin
         press(vecs[i].r, vecs[i].c);
         exp_q.push_back('{code: vecs[i].code, data: vecs[i].data, held: 1'b1});
         expect_pulse($sformatf("digit%0d", i), 120);
         release_all();
         wait_held_low(100, clks);
         check($sformatf("digit%0d_rel", i), 16'(key_held), 16'h0000);
         repeat (8) @(negedge clk);
      end
      check("wrap_data", data_out, 16'h23A5);

      // Key 0 bouncing once per tick, then settling
      for (int i = 0; i < 8; i++) begin
         k0_r  = 2'd3;
         k0_c  = 2'd1;
         k0_en = (i % 2 == 0);
         repeat (4) @(negedge clk);
      end
      check_no_new("bounce_no_valid");
      press(2'd3, 2'd1);
      exp_q.push_back('{code: 4'h0, data: 16'h3A50, held: 1'b1});
      expect_pulse("bounce_key0", 120);
      release_all();
      wait_held_low(100, clks);
      check("bounce_rel", 16'(key_held), 16'h0000);
      repeat (8) @(negedge clk);

      // Long hold of 9 with C pressed on top
      press(2'd2, 2'd2);
      exp_q.push_back('{code: 4'h9, data: 16'hA509, held: 1'b1});
      expect_pulse("hold9", 120);
      repeat (80) @(negedge clk);
      k1_r  = 2'd2;
      k1_c  = 2'd3;
      k1_en = 1'b1;
      repeat (80) @(negedge clk);
      check("hold9_held", 16'(key_held), 16'h0001);
      check_no_new("hold9_no_repeat");
      release_all();
      wait_held_low(100, clks);
      check("hold9_rel", 16'(key_held), 16'h0000);
      repeat (16) @(negedge clk);
      check_no_new("hold9_single");
      check("hold9_code", 16'(key_code), 16'h0009);
      check("hold9_data", data_out, 16'hA509);

      // Two columns low on one row
      k0_r = 2'd2; k0_c = 2'd1; k0_en = 1'b1;
      k1_r = 2'd2; k1_c = 2'd2; k1_en = 1'b1;
      repeat (120) @(negedge clk);
      check_no_new("multicol_no_valid");
      check("multicol_held", 16'(key_held), 16'h0000);
      release_all();
      repeat (8) @(negedge clk);

      // Reset landing inside press debounce: align press to row 0 being strobed
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rows != 4'b1110) break;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rows == 4'b1110) break;
      end
      press(2'd0, 2'd0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      release_all();
      rst_n = 1'b1;
      check("midrst_data", data_out, 16'h0000);
      check("midrst_rows", 16'(rows), 16'h000E);
      check("midrst_held", 16'(key_held), 16'h0000);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("midrst_scan_rows", 16'(rows), 16'h000D);
      repeat (40) @(negedge clk);
      check_no_new("midrst_no_valid");
      check("midrst_data_after", data_out, 16'h0000);

      check("valid_width", 16'(wide_cnt), 16'h0000);
      check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
